// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit sequencer.
// Optional multiply/divide support is selected by the MULDIV_EN macro.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  localparam logic [4:0] ALU_INCPC   = 5'd12;
  localparam logic [4:0] OP_MUL      = 5'd14;
  localparam logic [4:0] OP_DIV      = 5'd15;
  localparam logic [4:0] OP_NOP      = 5'd26;
  localparam logic [4:0] OP_HALT     = 5'd27;
  localparam logic [4:0] OP_RFMT_MAX = 5'd11;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

`ifdef MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  function automatic logic is_rfmt(input logic [4:0] op);
    return op <= OP_RFMT_MAX;
  endfunction

  // mul/div only count as executable when the feature is built in
  function automatic logic is_muldiv(input logic [4:0] op);
    return MULDIV_ON && ((op == OP_MUL) || (op == OP_DIV));
  endfunction

endpackage

// File: rtl/control_unit_reg_decoder.sv
// Purpose: 4-bit register index to 16-bit one-hot select, gated by enable.
// Latency: combinational.
// Backpressure: none; pure decode.
module reg_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot = 16'h0001 << idx;
  end

endmodule

// File: rtl/control_unit.sv
// Purpose: Moore-style fetch/execute sequencer driving datapath strobes; MULDIV_EN adds mul/div.
// Latency: 6 cycles per R-format instruction (T0..T5), 7 for mul/div (T0..T6).
// Backpressure: none; Stop is sampled on the final execute state, clr aborts anywhere.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  OpCode,
  output logic        Run
);

  state_t state, state_next;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       rfmt, muldiv, exec;
  logic       ra_en, rb_en, rc_en;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic       unused_ir;

  assign op        = IR[IR_OP_MSB:IR_OP_LSB];
  assign ra        = IR[IR_RA_MSB:IR_RA_LSB];
  assign rb        = IR[IR_RB_MSB:IR_RB_LSB];
  assign rc        = IR[IR_RC_MSB:IR_RC_LSB];
  assign rfmt      = is_rfmt(op);
  assign muldiv    = is_muldiv(op);
  assign exec      = rfmt | muldiv;
  assign unused_ir = ^IR[IR_RC_LSB-1:0];

  always_ff @(posedge clk) begin
    if (clr) state <= S_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (exec)              state_next = S_T4;
        else if (op == OP_NOP) state_next = S_T0;
        else                   state_next = S_HALT;
      end
      S_T4:    state_next = S_T5;
      S_T5: begin
        if (muldiv)    state_next = S_T6;
        else if (Stop) state_next = S_HALT;
        else           state_next = S_T0;
      end
      S_T6:    state_next = Stop ? S_HALT : S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  // Rb is read in T3, Rc in T4, Ra written in T5, so Ra=Rb=Rc never collides
  assign rb_en = (state == S_T3) && exec;
  assign rc_en = (state == S_T4);
  assign ra_en = (state == S_T5) && rfmt;

  reg_decoder u_dec_ra (.idx(ra), .en(ra_en), .onehot(ra_oh));
  reg_decoder u_dec_rb (.idx(rb), .en(rb_en), .onehot(rb_oh));
  reg_decoder u_dec_rc (.idx(rc), .en(rc_en), .onehot(rc_oh));

  assign Rout = rb_oh | rc_oh;
  assign Rin  = ra_oh;

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Read     = 1'b0;
    OpCode   = 5'd0;
    Run      = 1'b0;
    case (state)
      S_T0: begin
        Run    = 1'b1;
        PCout  = 1'b1;
        MARin  = 1'b1;
        Zin    = 1'b1;
        OpCode = ALU_INCPC;
      end
      S_T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        Yin = exec;
      end
      S_T4: begin
        Run    = 1'b1;
        Zin    = 1'b1;
        OpCode = op;
      end
      S_T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        LOin    = muldiv;
      end
      S_T6: begin
        Run      = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
